clk_divider_multi: RTL and testbench
====================================

// Module: clk_divider_multi
// PURPOSE
//  N-channel, runtime-programmable clock-enable/divider generator driven from one base clock.
//  Each channel produces a registered divided square wave (clk_out) and a one-cycle tick.
//  Divide ratios reload glitch-free at period boundaries. Replaces per-frequency fixed
//  dividers (e.g. 10/30/50/1 MHz from 100 MHz) in the lab top-levels.
// PARAMETERS
//  N_CH       4    number of independent channels (>=1)
//  CNT_W      16   divisor/counter width; max divisor 2**CNT_W-1
//  FREC_BASE  100  base clock frequency (MHz), used only for the reset divisor
//  FREC_DEF   10   default output frequency (MHz); DEF_DIV=FREC_BASE/FREC_DEF, must be >=2 (elab check)
// PORTS
//  clk_in     in   1         base clock, all logic on rising edge
//  reset      in   1         asynchronous, active-high
//  en         in   N_CH      per-channel run enable
//  cfg_valid  in   1         divisor write request
//  cfg_ready  out  1         = !pend[cfg_ch] (combinational); write accepted when valid&&ready
//  cfg_ch     in   CH_W      target channel, CH_W = (N_CH>1) ? $clog2(N_CH) : 1
//  cfg_div    in   CNT_W     new divisor
//  cfg_err    out  1         one-cycle pulse: accepted write was invalid, discarded
//  clk_out    out  N_CH      divided clock per channel (registered)
//  tick       out  N_CH      one-cycle pulse, first cycle of each clk_out high phase
// BEHAVIOUR
//  - Reset (async): cnt=DEF_DIV-1, div_act=DEF_DIV, pend=0, clk_out=0, tick=0, cfg_err=0.
//  - Per channel, enabled edge: cnt <= (cnt==div_act-1) ? 0 : cnt+1.
//    Wrap edge (cnt -> 0): clk_out<=1, tick<=1. Edge where cnt becomes HI=div_act>>1: clk_out<=0.
//    Other edges: tick<=0, clk_out holds. Result: period=div_act; high=floor(div/2), low=ceil(div/2).
//  - First rising edge of clk_out occurs on the first enabled edge after reset release (latency 1).
//  - Divisor update: accepted write with 2<=cfg_div and cfg_ch<N_CH stores shadow[ch], sets pend[ch].
//    Applied on that channel's next wrap edge: div_act<=shadow, pend<=0; HI recomputed from new value.
//    Running period is never truncated or stretched.
//  - Write accepted on the same edge as a wrap: not applied at this wrap; applied at the following one.
//  - Invalid accepted write (cfg_div<2 or cfg_ch>=N_CH): cfg_err=1 next cycle, no state change.
//  - cfg_ready low for a channel with pend=1; requester must hold cfg_valid/cfg_ch/cfg_div stable.
//  - en[ch]=0 on an edge: cnt<=div_act-1, clk_out<=0, tick<=0. Pending shadow applied immediately.
//    Re-enable behaves as reset release: rise on first enabled edge.
//  - Writing the same divisor as div_act is legal; it still sets pend and reloads at wrap, with no
//    visible change.
//  - Reset asserted mid-operation clears all channels immediately; no clock edge is needed; pending
//    writes are lost.
//  - Arithmetic unsigned CNT_W; no overflow because cnt<=div_act-1<=2**CNT_W-2.
// STRUCTURE
//  - clk_div_pkg: CNT_W default, DIV_MIN=2, function def_div(base,def) returning CNT_W-bit divisor.
//  - Sub-module clk_div_channel (one per channel, generate loop): counter, div_act, shadow, pend,
//    clk_out/tick regs.
//  - Top: cfg decode/validation, cfg_ready mux, cfg_err register.
// TESTING
//  1 Defaults 100/10, all en=1, reset low after 10 ns -> each clk_out period 10 clk_in cycles,
//    5 high/5 low, first rise 1 cycle after release, tick every 10 cycles.
//  2 Write ch1 div=4 mid-period -> cfg_ready low until wrap; period ends at 10, then 4-cycle period
//    (2/2); other channels unaffected.
//  3 div=2 -> clk_out toggles every cycle, tick every 2. div=3 -> high 1/low 2. div=65535 -> high 32767.
//  4 Write cfg_div=1, then cfg_div=0, then cfg_ch=N_CH (N_CH non-power-of-2 build) -> cfg_err pulses
//    1 cycle each, outputs unchanged.
//  5 Drop en[2] in high phase -> clk_out[2]=0 next edge. Write div=6 while disabled. Re-enable ->
//    rise next edge, period 6.
//  6 Assert reset asynchronously mid-high phase, between clk_in edges -> clk_out/tick go 0 at once,
//    pend cleared; after release, DEF_DIV timing resumes.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds the default counter width, the smallest legal divisor and the reset-divisor function.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_MIN   = 2;

    // Reset divisor from base/output frequency; a zero output frequency yields 0 so the elab check trips.
    function automatic logic [CNT_W_DEF-1:0] def_div(input int base, input int def_f);
        if (def_f == 0) begin
            return '0;
        end
        return CNT_W_DEF'(base / def_f);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/shadow divisor, pending flag and registered outputs.
// A new divisor only takes effect at a wrap, or at once while the channel is disabled.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int              CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             apply;

    assign last    = div_act - ONE;
    assign hi      = div_act >> 1;
    assign wrap    = (cnt == last);
    assign cnt_nxt = wrap ? '0 : cnt + ONE;
    // A write landing on this edge is held for the next boundary, never applied on the same edge.
    assign apply   = pend && !wr;

    always_ff @(posedge clk_in) begin
        if (wr) begin
            shadow <= wr_div;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= DEF_DIV - ONE;
            div_act <= DEF_DIV;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (wr) begin
                pend <= 1'b1;
            end
            if (!en) begin
                // Park at the last count so the first enabled edge wraps and raises clk_out.
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (apply) begin
                    div_act <= shadow;
                    cnt     <= shadow - ONE;
                    pend    <= 1'b0;
                end else begin
                    cnt <= last;
                end
            end else begin
                cnt <= cnt_nxt;
                if (wrap) begin
                    clk_out <= 1'b1;
                    tick    <= 1'b1;
                    if (apply) begin
                        div_act <= shadow;
                        pend    <= 1'b0;
                    end
                end else begin
                    tick <= 1'b0;
                    if (cnt_nxt == hi) begin
                        clk_out <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel runtime-programmable clock divider / tick generator on a single base clock.
// Decodes and validates divisor writes, gates them by per-channel pending state, flags bad writes.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FREC_BASE = 100,
    parameter int FREC_DEF  = 10,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    localparam int               DEF_DIV_I = FREC_BASE / ((FREC_DEF == 0) ? 1 : FREC_DEF);
    localparam logic [CNT_W-1:0] DEF_DIV   = CNT_W'(def_div(FREC_BASE, FREC_DEF));

    generate
        if (N_CH < 1) begin : g_bad_nch
            $error("clk_divider_multi: N_CH must be at least 1");
        end
        if (FREC_DEF == 0 || DEF_DIV_I < DIV_MIN) begin : g_bad_def
            $error("clk_divider_multi: FREC_BASE/FREC_DEF must be at least 2");
        end
    endgenerate

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] wr;
    logic            ch_ok;
    logic            accept;
    logic            div_ok;

    // Out-of-range channels report ready so the bad write is accepted and flagged.
    always_comb begin
        cfg_ready = 1'b1;
        ch_ok     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_ok     = 1'b1;
                cfg_ready = !pend[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;
    assign div_ok = (cfg_div >= CNT_W'(DIV_MIN));

    always_comb begin
        wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr[i] = accept && div_ok && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !(div_ok && ch_ok);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pend    (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi built with three channels and 100/10 defaults.
// Expected periods, phases and flags are hand-derived constants.
module tb_clk_divider_multi;

    localparam int N_CH  = 3;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;
    localparam int LIM   = 70000;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    always #5 clk_in = ~clk_in;

    clk_divider_multi #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .FREC_BASE (100),
        .FREC_DEF  (10)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_rise(input int ch, output int cnt);
        logic prev;
        cnt = 0;
        forever begin
            prev = clk_out[ch];
            step();
            cnt++;
            if (clk_out[ch] && !prev) break;
            if (cnt >= LIM) begin
                chk("rise_timeout", cnt, 0);
                break;
            end
        end
    endtask

    // Called on the sample where clk_out[ch] has just risen; ends on the next rise (or at the fall).
    task automatic measure(input string tag, input int ch, input int ehi, input int elo, input bit do_lo);
        int h, l, t;
        h = 0;
        l = 0;
        t = 0;
        chk({tag, "_rise_tick"}, tick[ch], 1);
        while (clk_out[ch] && h < LIM) begin
            h++;
            t += tick[ch];
            step();
        end
        chk({tag, "_high"}, h, ehi);
        if (do_lo) begin
            while (!clk_out[ch] && l < LIM) begin
                l++;
                t += tick[ch];
                step();
            end
            chk({tag, "_low"}, l, elo);
            chk({tag, "_ticks"}, t, 1);
        end
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(div);
    endtask

    initial begin
        reset     = 1'b1;
        en        = '1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;

        // Reset state and default 10-cycle timing
        #8;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        #2 reset = 1'b0;
        step();
        chk("first_rise", clk_out, 3'b111);
        chk("first_tick", tick, 3'b111);
        measure("def_ch0", 0, 5, 5, 1'b1);
        chk("def_all_rise", clk_out, 3'b111);
        chk("def_all_tick", tick, 3'b111);

        // Mid-period write of div=4 on channel 1
        step();
        step();
        cfg_write(1, 4);
        #0 chk("wr4_ready_before", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("wr4_ready_pend", cfg_ready, 0);
        wait_rise(1, n);
        chk("wr4_old_period_end", n, 7);
        chk("wr4_ready_after", cfg_ready, 1);
        measure("div4_a", 1, 2, 2, 1'b1);
        measure("div4_b", 1, 2, 2, 1'b1);
        chk("wr4_ch0_unaffected", clk_out[0], 0);
        chk("wr4_no_err", cfg_err, 0);

        // div=2, then div=3 written on a wrap edge, then the largest divisor
        cfg_write(1, 2);
        step();
        cfg_valid = 1'b0;
        wait_rise(1, n);
        chk("div2_apply_wait", n, 3);
        measure("div2_a", 1, 1, 1, 1'b1);
        measure("div2_b", 1, 1, 1, 1'b1);
        step();
        cfg_write(1, 3);
        step();
        cfg_valid = 1'b0;
        chk("wrap_wr_rise", clk_out[1], 1);
        chk("wrap_wr_pend", cfg_ready, 0);
        measure("wrap_wr_old", 1, 1, 1, 1'b1);
        measure("div3_a", 1, 1, 2, 1'b1);
        measure("div3_b", 1, 1, 2, 1'b1);
        cfg_write(1, 65535);
        step();
        cfg_valid = 1'b0;
        wait_rise(1, n);
        chk("div_max_apply_wait", n, 2);
        measure("div_max", 1, 32767, 0, 1'b0);

        // Invalid writes: divisor 1, divisor 0, channel out of range
        cfg_write(0, 1);
        step();
        cfg_valid = 1'b0;
        chk("err_div1", cfg_err, 1);
        chk("err_div1_ready", cfg_ready, 1);
        step();
        chk("err_div1_clear", cfg_err, 0);
        cfg_write(0, 0);
        step();
        cfg_valid = 1'b0;
        chk("err_div0", cfg_err, 1);
        step();
        chk("err_div0_clear", cfg_err, 0);
        cfg_write(3, 5);
        #0 chk("err_ch_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("err_ch3", cfg_err, 1);
        step();
        chk("err_ch3_clear", cfg_err, 0);
        cfg_ch = 2'd0;
        wait_rise(0, n);
        measure("err_ch0_keep", 0, 5, 5, 1'b1);

        // Disable channel 2 in its high phase, reprogram while off, re-enable
        wait_rise(2, n);
        step();
        en = 3'b011;
        step();
        chk("dis_low", clk_out[2], 0);
        chk("dis_tick", tick[2], 0);
        cfg_write(2, 6);
        #0 chk("dis_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("dis_pend", cfg_ready, 0);
        step();
        chk("dis_applied", cfg_ready, 1);
        step();
        chk("dis_still_low", clk_out[2], 0);
        en = 3'b111;
        step();
        chk("reen_rise", clk_out[2], 1);
        measure("div6", 2, 3, 3, 1'b1);

        // Asynchronous reset in the middle of a high phase with a write pending
        cfg_write(2, 4);
        step();
        cfg_valid = 1'b0;
        chk("pre_rst_pend", cfg_ready, 0);
        chk("pre_rst_high", clk_out[2], 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_tick", tick, 0);
        chk("arst_ready", cfg_ready, 1);
        #2 reset = 1'b0;
        step();
        chk("arst_first_rise", clk_out, 3'b111);
        measure("arst_def", 2, 5, 5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
